// File: rtl/pocket_i2s_pkg.sv
// Shared types and framing constants for the Pocket I2S audio path.
package pocket_i2s_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

  localparam int I2S_WORD_BITS = 16;
  localparam int I2S_SLOT_BITS = 32;

endpackage

// File: rtl/i2s_input_sync.sv
// Two-flop synchronizer for an asynchronous pin plus an edge register
// providing single-cycle rise/fall strobes in the clk_74a domain.
module i2s_input_sync (
  input  logic clk_74a,
  input  logic reset_n,
  input  logic din,
  output logic din_sync,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic edge_q, edge_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    edge_d = sync_q;
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign din_sync = sync_q;
  assign rise     = sync_q & ~edge_q;
  assign fall     = ~sync_q & edge_q;

endmodule

// File: rtl/i2s_audio_rx.sv
// I2S receiver: recovers 16-bit left/right words from SCLK/LRCK/SDATA and
// presents them as a stereo pair with a one-cycle valid strobe.
module i2s_audio_rx
  import pocket_i2s_pkg::*;
#(
  parameter int CHANNEL_WIDTH  = 15,
  parameter int SIGNED_OUTPUT  = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk_74a,
  input  logic                     reset_n,
  input  logic                     i2s_sclk,
  input  logic                     i2s_lrck,
  input  logic                     i2s_sdata,
  output logic [CHANNEL_WIDTH-1:0] audio_l,
  output logic [CHANNEL_WIDTH-1:0] audio_r,
  output logic                     sample_valid,
  output logic                     locked,
  output logic                     frame_error
);

  localparam int SLICE_MSB = (SIGNED_OUTPUT != 0) ? I2S_WORD_BITS - 1 : I2S_WORD_BITS - 2;
  localparam int IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0]        CNT_FULL = 5'(I2S_WORD_BITS);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  // Unsigned mode drops the sign bit and keeps the next CHANNEL_WIDTH bits.
  function automatic logic [CHANNEL_WIDTH-1:0] slice(input logic [I2S_WORD_BITS-1:0] w);
    return w[SLICE_MSB -: CHANNEL_WIDTH];
  endfunction

  logic sclk_rise, sclk_level_unused, sclk_fall_unused;
  logic lrck_s, lrck_rise_unused, lrck_fall_unused;

  i2s_input_sync u_sclk_sync (
    .clk_74a  (clk_74a),
    .reset_n  (reset_n),
    .din      (i2s_sclk),
    .din_sync (sclk_level_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall_unused)
  );

  i2s_input_sync u_lrck_sync (
    .clk_74a  (clk_74a),
    .reset_n  (reset_n),
    .din      (i2s_lrck),
    .din_sync (lrck_s),
    .rise     (lrck_rise_unused),
    .fall     (lrck_fall_unused)
  );

  logic sdata_meta_q, sdata_meta_d, sdata_q, sdata_d;

  i2s_rx_state_t              state_q, state_d;
  logic [4:0]                 bit_cnt_q, bit_cnt_d;
  logic [I2S_WORD_BITS-1:0]   word_q, word_d;
  logic [I2S_WORD_BITS-1:0]   left_hold_q, left_hold_d;
  logic                       lrck_last_q, lrck_last_d;
  logic [IDLE_W-1:0]          idle_q, idle_d;
  logic [CHANNEL_WIDTH-1:0]   audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic                       valid_q, valid_d, locked_q, locked_d, ferr_q, ferr_d;

  // LRCK transitions are judged only between consecutive SCLK rises.
  logic lr_fall, lr_rise;
  assign lr_fall = lrck_last_q & ~lrck_s;
  assign lr_rise = ~lrck_last_q & lrck_s;

  always_comb begin
    sdata_meta_d = i2s_sdata;
    sdata_d      = sdata_meta_q;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_d       = word_q;
    left_hold_d  = left_hold_q;
    lrck_last_d  = lrck_last_q;
    idle_d       = idle_q;
    audio_l_d    = audio_l_q;
    audio_r_d    = audio_r_q;
    valid_d      = 1'b0;
    locked_d     = locked_q;
    ferr_d       = ferr_q;

    if (sclk_rise) begin
      idle_d      = '0;
      lrck_last_d = lrck_s;
      // The rise that first sees a new LRCK carries the old slot's LSB.
      if (lr_fall || lr_rise) begin
        bit_cnt_d = '0;
      end else if (state_q != SYNC && bit_cnt_q < CNT_FULL) begin
        word_d    = {word_q[I2S_WORD_BITS-2:0], sdata_q};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end

      unique case (state_q)
        SYNC: begin
          if (lr_fall) state_d = LEFT;
        end
        LEFT: begin
          if (lr_rise) begin
            if (bit_cnt_q == CNT_FULL) begin
              left_hold_d = word_q;
              state_d     = RIGHT;
            end else begin
              ferr_d   = 1'b1;
              locked_d = 1'b0;
              state_d  = SYNC;
            end
          end
        end
        RIGHT: begin
          if (lr_fall) begin
            if (bit_cnt_q == CNT_FULL) begin
              audio_l_d = slice(left_hold_q);
              audio_r_d = slice(word_q);
              valid_d   = 1'b1;
              locked_d  = 1'b1;
              state_d   = LEFT;
            end else begin
              ferr_d   = 1'b1;
              locked_d = 1'b0;
              state_d  = SYNC;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end else if (idle_q == IDLE_MAX) begin
      state_d  = SYNC;
      locked_d = 1'b0;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      sdata_meta_q <= 1'b0;
      sdata_q      <= 1'b0;
      state_q      <= SYNC;
      bit_cnt_q    <= '0;
      word_q       <= '0;
      left_hold_q  <= '0;
      lrck_last_q  <= 1'b0;
      idle_q       <= '0;
      audio_l_q    <= '0;
      audio_r_q    <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      sdata_meta_q <= sdata_meta_d;
      sdata_q      <= sdata_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      left_hold_q  <= left_hold_d;
      lrck_last_q  <= lrck_last_d;
      idle_q       <= idle_d;
      audio_l_q    <= audio_l_d;
      audio_r_q    <= audio_r_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      ferr_q       <= ferr_d;
    end
  end

  assign audio_l      = audio_l_q;
  assign audio_r      = audio_r_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign frame_error  = ferr_q;

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Bench for i2s_audio_rx: an I2S BFM drives a signed 16-bit and an unsigned
// 15-bit receiver in parallel; frames are scoreboarded against both.
`timescale 1ns/1ps
module tb_i2s_audio_rx;
  import pocket_i2s_pkg::*;

  logic clk_74a   = 1'b0;
  logic reset_n   = 1'b0;
  logic i2s_sclk  = 1'b0;
  logic i2s_lrck  = 1'b0;
  logic i2s_sdata = 1'b0;

  logic [15:0] audio_l16, audio_r16;
  logic [14:0] audio_l15, audio_r15;
  logic        sv16, sv15, locked16, locked15, ferr16, ferr15;

  always #5 clk_74a = ~clk_74a;

  i2s_audio_rx #(.CHANNEL_WIDTH(16), .SIGNED_OUTPUT(1), .TIMEOUT_CYCLES(4096)) dut16 (
    .clk_74a(clk_74a), .reset_n(reset_n), .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck),
    .i2s_sdata(i2s_sdata), .audio_l(audio_l16), .audio_r(audio_r16),
    .sample_valid(sv16), .locked(locked16), .frame_error(ferr16)
  );

  i2s_audio_rx #(.CHANNEL_WIDTH(15), .SIGNED_OUTPUT(0), .TIMEOUT_CYCLES(4096)) dut15 (
    .clk_74a(clk_74a), .reset_n(reset_n), .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck),
    .i2s_sdata(i2s_sdata), .audio_l(audio_l15), .audio_r(audio_r15),
    .sample_valid(sv15), .locked(locked15), .frame_error(ferr15)
  );

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;

  frame_t sb_q[$];
  frame_t exp_f;
  int     n_assert = 0;
  int     n_fail   = 0;
  int     n_push   = 0;
  int     n_valid  = 0;
  logic   prev_v   = 1'b0;
  int     half_base = 12;
  logic   jitter    = 1'b0;
  logic   pend_bit  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic data_bit(input logic [15:0] w, input int j);
    return (j < 16) ? w[15-j] : 1'b0;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_74a);
    #1;
  endtask

  // One SCLK period: data and LRCK change while SCLK is low.
  task automatic drive_bit(input logic lr, input logic d);
    int h;
    i2s_sclk  = 1'b0;
    i2s_lrck  = lr;
    i2s_sdata = d;
    h = half_base + (jitter ? int'($urandom_range(2)) - 1 : 0);
    wait_clks(h);
    i2s_sclk = 1'b1;
    h = half_base + (jitter ? int'($urandom_range(2)) - 1 : 0);
    wait_clks(h);
  endtask

  // First period of a slot carries the previous slot's trailing bit.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int len);
    drive_bit(lr, pend_bit);
    for (int p = 1; p < len; p++) drive_bit(lr, data_bit(w, p - 1));
    pend_bit = data_bit(w, len - 1);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int len,
                            input logic expect_out);
    if (expect_out) begin
      sb_q.push_back({l, r});
      n_push++;
    end
    send_slot(1'b0, l, len);
    send_slot(1'b1, r, len);
  endtask

  always @(negedge clk_74a) begin
    if (sv16 || sv15) begin
      n_valid++;
      check("valid_pair", 32'(sv15), 32'(sv16));
      check("valid_consec", 32'(prev_v), 0);
      check("locked_on_valid", 32'(locked16 && locked15), 1);
      check("sb_nonempty", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        exp_f = sb_q.pop_front();
        check("l16", 32'(audio_l16), 32'(exp_f.l));
        check("r16", 32'(audio_r16), 32'(exp_f.r));
        check("l15", 32'(audio_l15), 32'(exp_f.l[14:0]));
        check("r15", 32'(audio_r15), 32'(exp_f.r[14:0]));
      end
    end
    prev_v <= sv16;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, v1, v2;
    logic [15:0] w, l, r;
    int len;

    wait_clks(3);
    check("rst_l16", 32'(audio_l16), 0);
    check("rst_r16", 32'(audio_r16), 0);
    check("rst_l15", 32'(audio_l15), 0);
    check("rst_r15", 32'(audio_r15), 0);
    check("rst_valid", 32'(sv16 | sv15), 0);
    check("rst_locked", 32'(locked16 | locked15), 0);
    check("rst_ferr", 32'(ferr16 | ferr15), 0);
    reset_n = 1'b1;
    wait_clks(4);

    // Directed frames at nominal bit rate; first frame only primes LRCK.
    send_frame(16'h5A5A, 16'hA5A5, I2S_SLOT_BITS, 1'b0);
    send_frame(16'h1234, 16'h8765, I2S_SLOT_BITS, 1'b1);
    send_frame(16'h7FFF, 16'h0001, I2S_SLOT_BITS, 1'b1);
    check("dir_valid_cnt", n_valid, 1);
    check("dir_l16", 32'(audio_l16), 32'h1234);
    check("dir_r16", 32'(audio_r16), 32'h8765);
    check("dir_r15", 32'(audio_r15), 32'h0765);
    check("dir_locked", 32'(locked16), 1);

    // Random frames, odd slot lengths, jittered SCLK.
    half_base = 6;
    jitter    = 1'b1;
    v0 = 0;
    for (int i = 0; i < 100; i++) begin
      l   = 16'($urandom);
      r   = 16'($urandom);
      len = 17 + int'($urandom_range(3));
      sb_q.push_back({l, r});
      n_push++;
      send_slot(1'b0, l, len);
      if (i == 0) v0 = n_valid;
      send_slot(1'b1, r, len);
    end
    half_base = 12;
    jitter    = 1'b0;
    send_slot(1'b0, 16'hCAFE, I2S_SLOT_BITS);
    check("rand_valid_cnt", n_valid - v0, 100);
    check("rand_ferr", 32'(ferr16 | ferr15), 0);
    check("rand_locked", 32'(locked16 & locked15), 1);

    // Short right slot.
    v1 = n_valid;
    send_slot(1'b1, 16'hBEEF, 12);
    send_slot(1'b0, 16'h1111, I2S_SLOT_BITS);
    check("short_ferr16", 32'(ferr16), 1);
    check("short_ferr15", 32'(ferr15), 1);
    check("short_locked", 32'(locked16 | locked15), 0);
    send_slot(1'b1, 16'h2222, I2S_SLOT_BITS);
    check("short_no_pulse", n_valid, v1);
    send_frame(16'h0F0F, 16'hF0F0, I2S_SLOT_BITS, 1'b1);
    send_slot(1'b0, 16'h3333, I2S_SLOT_BITS);
    check("recover_pulse", n_valid, v1 + 1);

    // SCLK stops.
    i2s_sclk = 1'b0;
    wait_clks(4000);
    check("to_before", 32'(locked16 & locked15), 1);
    wait_clks(200);
    check("to_locked16", 32'(locked16), 0);
    check("to_locked15", 32'(locked15), 0);
    check("to_hold_l16", 32'(audio_l16), 32'h0F0F);
    check("to_hold_r16", 32'(audio_r16), 32'hF0F0);
    check("to_hold_r15", 32'(audio_r15), 32'h70F0);
    check("to_ferr_sticky", 32'(ferr16), 1);
    wait_clks(800);

    // Resume, relock, then reset mid left slot.
    send_frame(16'h4444, 16'h5555, I2S_SLOT_BITS, 1'b0);
    send_frame(16'h9ABC, 16'hDEF0, I2S_SLOT_BITS, 1'b1);
    w = 16'h1357;
    drive_bit(1'b0, pend_bit);
    for (int p = 1; p < 8; p++) drive_bit(1'b0, data_bit(w, p - 1));
    check("relock_l16", 32'(audio_l16), 32'h9ABC);
    @(negedge clk_74a);
    reset_n = 1'b0;
    #1;
    check("mid_rst_l16", 32'(audio_l16), 0);
    check("mid_rst_r15", 32'(audio_r15), 0);
    check("mid_rst_locked", 32'(locked16 | locked15), 0);
    check("mid_rst_ferr", 32'(ferr16 | ferr15), 0);
    repeat (3) @(negedge clk_74a);
    reset_n = 1'b1;
    v2 = n_valid;
    for (int p = 8; p < I2S_SLOT_BITS; p++) drive_bit(1'b0, data_bit(w, p - 1));
    pend_bit = data_bit(w, I2S_SLOT_BITS - 1);
    send_slot(1'b1, 16'h2468, I2S_SLOT_BITS);
    send_frame(16'hFACE, 16'h0123, I2S_SLOT_BITS, 1'b1);
    check("post_rst_no_pulse", n_valid, v2);
    send_slot(1'b0, 16'h0000, I2S_SLOT_BITS);
    check("post_rst_pulse", n_valid, v2 + 1);
    check("post_rst_ferr", 32'(ferr16 | ferr15), 0);

    wait_clks(4);
    check("sb_drained", sb_q.size(), 0);
    check("valid_total", n_valid, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
